// File: rtl/lsu.sv
// Load/store unit: aligns stores, extends loads, and runs a req/gnt/rvalid memory handshake.
// Latency: store 2 cycles, load 3 cycles, fault 1 cycle from the start edge; +1 per gnt/rvalid wait cycle.
// Backpressure: mem_req and its fields are held until mem_gnt; busy holds upstream until after done.
module lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             access_ok;
  logic [3:0]       be_calc;
  logic [WIDTH-1:0] wdata_calc;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [WIDTH-1:0] load_ext;

  // Legality of the incoming access: width code must exist and the offset must be naturally aligned.
  always_comb begin
    access_ok = 1'b0;
    case ({is_store, funct3})
      4'b0_000, 4'b0_100, 4'b1_000: access_ok = 1'b1;
      4'b0_001, 4'b0_101, 4'b1_001: access_ok = ~addr[0];
      4'b0_010, 4'b1_010:           access_ok = (addr[1:0] == 2'b00);
      default:                      access_ok = 1'b0;
    endcase
  end

  // Byte-enable mask and lane-replicated store data from the request width and offset.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  // Pick the addressed byte/half lane out of the returned word.
  always_comb begin
    lane_b = mem_rdata[7:0];
    case (off_q)
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Sign- or zero-extend the selected lane according to the latched load type.
  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/REQ/WAIT/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          addr_d     = {addr[WIDTH-1:2], 2'b00};
          be_d       = be_calc;
          wdata_d    = wdata_calc;
          busy_d     = 1'b1;
          if (access_ok) begin
            // Legal access: present the request on the very next cycle.
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_store;
          end else begin
            // Trap without touching memory.
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
      end

      REQ: begin
        if (mem_gnt) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (is_store_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // Any rvalid seen alongside gnt is dropped; data must come in WAIT.
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus randomized transactions against a behavioural model.
// Inputs are driven and outputs sampled on the falling clock edge.
// The bench plays the memory, inserting random gnt/rvalid wait cycles.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata;
  int          last_done_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] f3, input logic [1:0] off);
    bit code_ok;
    if (st) code_ok = (f3 <= 3'd2);
    else    code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return code_ok && ((int'(off) % nbytes(f3)) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    int m;
    m = ((1 << nbytes(f3)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    longint v;
    longint span;
    int n;
    n    = nbytes(f3);
    span = 64'd1 << (8 * n);
    v    = (longint'(word) >> (8 * int'(off))) % span;
    if (f3[2] == 1'b0 && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- one transaction with memory responder ----------------
  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int g, input int r, input bit rv_early, input bit force_spur);
    bit          ok;
    logic [1:0]  off;
    int          exp_cyc;
    int          req_cnt;
    int          wait_cnt;
    bit          granted;
    bit          seen;
    logic [31:0] rr;
    off     = a[1:0];
    ok      = legal(st, f3, off);
    exp_cyc = !ok ? 1 : (st ? 2 + g : 3 + g + r);

    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    req_cnt = 0; wait_cnt = 0; granted = 1'b0; seen = 1'b0;

    for (int k = 1; k <= 60 && !seen; k++) begin
      if (mem_gnt) granted = 1'b1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom; start = 1'b0;
      if (done) begin
        seen = 1'b1;
        last_done_cyc = k;
        chk("done_cycle", 32'(k), 32'(exp_cyc));
        chk("fault", {31'd0, fault}, {31'd0, !ok});
        chk("req_in_done", {31'd0, mem_req}, 32'd0);
        chk("req_cycles", 32'(req_cnt), ok ? 32'(g + 1) : 32'd0);
        if (ok && !st) exp_rdata = model_load(f3, off, rd);
        chk("rdata", rdata, exp_rdata);
      end else begin
        chk("busy_hi", {31'd0, busy}, 32'd1);
        if (mem_req) begin
          req_cnt++;
          chk("mem_addr", mem_addr, {a[31:2], 2'b00});
          chk("mem_be", {28'd0, mem_be}, {28'd0, model_be(f3, off)});
          chk("mem_we", {31'd0, mem_we}, {31'd0, st});
          if (st) chk("mem_wdata", mem_wdata, model_wdata(f3, wd));
          if (req_cnt == g + 1) begin
            mem_gnt = 1'b1;
            if (rv_early) mem_rvalid = 1'b1;
          end
        end else if (granted && !st) begin
          wait_cnt++;
          if (wait_cnt == r + 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
          end
        end
        if ((force_spur && k == 2) || $urandom_range(0, 4) == 0) begin
          rr = $urandom;
          start = 1'b1; is_store = rr[0]; funct3 = rr[3:1];
          addr = $urandom; wdata = $urandom;
        end
      end
      if (!seen) @(negedge clk);
    end
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (!seen) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_rdata = '0;
    end
  endtask

  localparam logic [31:0] RD_PAT = 32'h80F17F80;

  initial begin
    logic [31:0] rr;
    rst_n = 1'b0; start = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h0; wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_rdata = '0; last_done_cyc = 0;

    // Reset with start held high.
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy",  {31'd0, busy},    32'd0);
      chk("rst_done",  {31'd0, done},    32'd0);
      chk("rst_fault", {31'd0, fault},   32'd0);
      chk("rst_req",   {31'd0, mem_req}, 32'd0);
      chk("rst_we",    {31'd0, mem_we},  32'd0);
      chk("rst_addr",  mem_addr,         32'd0);
      chk("rst_be",    {28'd0, mem_be},  32'd0);
      chk("rst_wdata", mem_wdata,        32'd0);
      chk("rst_rdata", rdata,            32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;

    // SB into the top lane.
    do_txn(1'b1, 3'b000, 32'h0000_1003, 32'hAABBCCDD, 32'h0, 0, 0, 1'b0, 1'b0);
    chk("sb_latency", 32'(last_done_cyc), 32'd2);

    // Signed / unsigned loads.
    do_txn(1'b0, 3'b000, 32'h0000_0101, 32'h0, RD_PAT, 0, 0, 1'b0, 1'b0);
    chk("lb_off1", rdata, 32'h0000007F);
    do_txn(1'b0, 3'b000, 32'h0000_0100, 32'h0, RD_PAT, 0, 0, 1'b1, 1'b0);
    chk("lb_off0", rdata, 32'hFFFFFF80);
    do_txn(1'b0, 3'b100, 32'h0000_0100, 32'h0, RD_PAT, 1, 0, 1'b0, 1'b0);
    chk("lbu_off0", rdata, 32'h00000080);
    do_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, RD_PAT, 0, 1, 1'b0, 1'b0);
    chk("lh_off2", rdata, 32'hFFFF80F1);
    do_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, RD_PAT, 0, 0, 1'b0, 1'b0);
    chk("lhu_off2", rdata, 32'h000080F1);

    // Misaligned and illegal accesses leave rdata alone.
    do_txn(1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h12345678, 0, 0, 1'b0, 1'b0);
    chk("lw_mis_rdata", rdata, 32'h000080F1);
    do_txn(1'b1, 3'b001, 32'h0000_2001, 32'h55AA55AA, 32'h0, 0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 3'b011, 32'h0000_2000, 32'h0, 32'h12345678, 0, 0, 1'b0, 1'b0);
    chk("ill_rdata", rdata, 32'h000080F1);

    // Wait states with a spurious start mid-transaction.
    do_txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEADBEEF, 3, 2, 1'b1, 1'b1);
    chk("wait_latency", 32'(last_done_cyc), 32'd8);
    chk("wait_rdata", rdata, 32'hDEADBEEF);

    // Back-to-back SW then LW.
    do_txn(1'b1, 3'b010, 32'h0000_4000, 32'h01234567, 32'h0, 0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h01234567, 0, 0, 1'b0, 1'b0);

    // Reset while waiting for load data.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    start = 1'b0;
    chk("rw_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rw_wait_req", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    chk("rw_busy",  {31'd0, busy},    32'd0);
    chk("rw_done",  {31'd0, done},    32'd0);
    chk("rw_req0",  {31'd0, mem_req}, 32'd0);
    chk("rw_rdata", rdata,            32'd0);
    repeat (3) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rw_no_done", {31'd0, done}, 32'd0);
      chk("rw_idle",    {31'd0, busy}, 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      rr = $urandom;
      do_txn(rr[0], rr[3:1], $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), rr[4], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
